// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory stage: FSM state encoding,
// default geometry/latency and the busy-counter width.
package memory_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEPTH_DEF   = 256;
    localparam int LATENCY_DEF = 2;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/memory_stage_dmem_array.sv
// Word-addressed data memory: one synchronous write port, one combinational
// read port at the same index. Contents are never reset.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: multi-cycle data-memory access controller that stalls
// the pipeline for LATENCY+1 cycles per aligned load/store.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] RD,
    output logic        StallM,
    output logic        MisalignM
);

    localparam int AW = $clog2(DEPTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rd_q, rd_d;
    logic             we;
    logic [31:0]      mem_rdata;
    logic             access, req, mis;

    // Upper address bits alias onto the array and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ALUOutM[31:AW+2];

    assign access = MemReadM | MemWriteM;
    assign req    = access & (ALUOutM[1:0] == 2'b00);
    assign mis    = access & (ALUOutM[1:0] != 2'b00);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        we        = 1'b0;
        StallM    = 1'b0;
        MisalignM = mis;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    StallM  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end else if (mis) begin
                    rd_d = 32'd0;
                end
            end
            BUSY: begin
                StallM = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    // A combined read+write request behaves as a store that clears RD.
                    if (MemWriteM) begin
                        we = ~reset;
                        if (MemReadM) rd_d = 32'd0;
                    end else begin
                        rd_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    assign RD = rd_q;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clock   (clock),
        .we_i    (we),
        .idx_i   (ALUOutM[AW+1:2]),
        .wdata_i (WriteDataM),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage (DEPTH=256, LATENCY=2).
module tb_memory_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        MemWriteM, MemReadM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [31:0] RD;
    logic        StallM, MisalignM;

    int tests  = 0;
    int failed = 0;

    memory_stage #(.DEPTH(256), .LATENCY(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .RD         (RD),
        .StallM     (StallM),
        .MisalignM  (MisalignM)
    );

    always #5 clock = ~clock;

    // Drive a request in an IDLE cycle, count stall cycles; returns at the
    // falling edge of the first non-stall (DONE) cycle with inputs still held.
    task automatic start_access(input logic wr, input logic rd, input logic [31:0] a,
                                input logic [31:0] d, output int ncyc);
        @(posedge clock); #1;
        MemWriteM = wr; MemReadM = rd; ALUOutM = a; WriteDataM = d;
        ncyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (StallM) ncyc++;
            else break;
        end
    endtask

    task automatic idle_in();
        @(posedge clock); #1;
        MemWriteM = 1'b0; MemReadM = 1'b0; ALUOutM = 32'd0; WriteDataM = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        MemWriteM = 1'b0; MemReadM = 1'b0; ALUOutM = 32'd0; WriteDataM = 32'd0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        tests++; if (StallM !== 1'b0) begin failed++; $display("FAIL reset_stall got %b want 0", StallM); end
        tests++; if (MisalignM !== 1'b0) begin failed++; $display("FAIL reset_misalign got %b want 0", MisalignM); end
        tests++; if (RD !== 32'd0) begin failed++; $display("FAIL reset_rd got %h want 0", RD); end
    endtask

    task automatic test_store();
        int n;
        start_access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, n);
        tests++; if (n != 3) begin failed++; $display("FAIL store_stall_cycles got %0d want 3", n); end
        tests++; if (RD !== 32'd0) begin failed++; $display("FAIL store_rd got %h want 0", RD); end
        idle_in();
    endtask

    task automatic test_load();
        int n;
        start_access(1'b0, 1'b1, 32'h10, 32'h0, n);
        tests++; if (n != 3) begin failed++; $display("FAIL load_stall_cycles got %0d want 3", n); end
        tests++; if (RD !== 32'hDEADBEEF) begin failed++; $display("FAIL load_rd got %h want deadbeef", RD); end
        idle_in();
    endtask

    task automatic test_misalign();
        int n;
        @(negedge clock);
        MemReadM = 1'b0; MemWriteM = 1'b0; ALUOutM = 32'h13;
        #1;
        tests++; if (MisalignM !== 1'b0) begin failed++; $display("FAIL misalign_noreq got %b want 0", MisalignM); end
        @(posedge clock); #1;
        MemReadM = 1'b1;
        @(negedge clock);
        tests++; if (MisalignM !== 1'b1) begin failed++; $display("FAIL misalign_flag got %b want 1", MisalignM); end
        tests++; if (StallM !== 1'b0) begin failed++; $display("FAIL misalign_stall got %b want 0", StallM); end
        idle_in();
        @(negedge clock);
        tests++; if (RD !== 32'd0) begin failed++; $display("FAIL misalign_rd got %h want 0", RD); end
        // Misaligned store must not touch the array.
        @(posedge clock); #1;
        MemWriteM = 1'b1; ALUOutM = 32'h11; WriteDataM = 32'h0BADF00D;
        idle_in();
        start_access(1'b0, 1'b1, 32'h10, 32'h0, n);
        tests++; if (RD !== 32'hDEADBEEF) begin failed++; $display("FAIL misalign_reload got %h want deadbeef", RD); end
        idle_in();
    endtask

    task automatic test_alias();
        int n;
        start_access(1'b1, 1'b0, 32'h410, 32'h12345678, n);
        idle_in();
        start_access(1'b0, 1'b1, 32'h010, 32'h0, n);
        tests++; if (RD !== 32'h12345678) begin failed++; $display("FAIL alias_rd got %h want 12345678", RD); end
        idle_in();
    endtask

    task automatic test_both();
        int n;
        start_access(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, n);
        tests++; if (n != 3) begin failed++; $display("FAIL both_stall_cycles got %0d want 3", n); end
        tests++; if (RD !== 32'd0) begin failed++; $display("FAIL both_rd got %h want 0", RD); end
        idle_in();
        start_access(1'b0, 1'b1, 32'h30, 32'h0, n);
        tests++; if (RD !== 32'hA5A5A5A5) begin failed++; $display("FAIL both_written got %h want a5a5a5a5", RD); end
        idle_in();
    endtask

    task automatic test_reset_busy();
        int n;
        start_access(1'b1, 1'b0, 32'h20, 32'h11112222, n);
        idle_in();
        @(posedge clock); #1;
        MemWriteM = 1'b1; ALUOutM = 32'h20; WriteDataM = 32'hCAFEF00D;
        @(posedge clock); #1;           // first BUSY cycle
        @(posedge clock); #1;           // second BUSY cycle: reset at the completing edge
        reset = 1'b1;
        MemWriteM = 1'b0; ALUOutM = 32'h0; WriteDataM = 32'h0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        tests++; if (StallM !== 1'b0) begin failed++; $display("FAIL rstbusy_stall got %b want 0", StallM); end
        tests++; if (RD !== 32'd0) begin failed++; $display("FAIL rstbusy_rd got %h want 0", RD); end
        start_access(1'b0, 1'b1, 32'h20, 32'h0, n);
        tests++; if (n != 3) begin failed++; $display("FAIL rstbusy_idle got %0d stall cycles want 3", n); end
        tests++; if (RD !== 32'h11112222) begin failed++; $display("FAIL rstbusy_old got %h want 11112222", RD); end
        idle_in();
    endtask

    task automatic test_back_to_back();
        int n;
        start_access(1'b1, 1'b0, 32'h40, 32'h00000077, n);
        tests++; if (StallM !== 1'b0) begin failed++; $display("FAIL b2b_done_stall got %b want 0", StallM); end
        // Inputs still held: the following IDLE cycle accepts a fresh request.
        @(posedge clock);
        @(negedge clock);
        tests++; if (StallM !== 1'b1) begin failed++; $display("FAIL b2b_reaccept got %b want 1", StallM); end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (StallM) n++;
            else break;
        end
        tests++; if (n != 3) begin failed++; $display("FAIL b2b_second_stall got %0d want 3", n); end
        idle_in();
        start_access(1'b0, 1'b1, 32'h40, 32'h0, n);
        tests++; if (RD !== 32'h00000077) begin failed++; $display("FAIL b2b_rd got %h want 00000077", RD); end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_misalign();
        test_alias();
        test_both();
        test_reset_busy();
        test_back_to_back();
        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
